// File: rtl/floatb_pkg.sv
// Shared widths, helpers and float layout for the FLOATB pipeline.
// G.726 defaults plus width derivations used by the top and the detector.
package floatb_pkg;

   localparam int G726_DW = 16;
   localparam int G726_MW = 6;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   function automatic int exp_w(input int dw);
      return clog2(dw);
   endfunction

   function automatic int fl_w(input int dw, input int mw);
      return 1 + clog2(dw) + mw;
   endfunction

   function automatic int ch_w(input int ch);
      return (ch > 1) ? clog2(ch) : 1;
   endfunction

   localparam int G726_EW = exp_w(G726_DW);
   localparam int G726_OW = fl_w(G726_DW, G726_MW);

   typedef struct packed {
      logic                sign;
      logic [G726_EW-1:0]  exp;
      logic [G726_MW-1:0]  mant;
   } g726_fl_t;

endpackage

// File: rtl/floatb_lzd.sv
// Leading-one detector: exponent is the leading-one index plus one.
// A zero input gives exponent 0 and raises the zero flag.
module floatb_lzd
   import floatb_pkg::*;
#(
   parameter int N  = 15,
   parameter int EW = clog2(N + 1)
) (
   input  logic [N-1:0]  mag,
   output logic [EW-1:0] exp,
   output logic          zero
);

   always_comb begin
      exp = '0;
      for (int i = 0; i < N; i++)
         if (mag[i]) exp = EW'(i + 1);
   end

   assign zero = (mag == '0);

endmodule

// File: rtl/floatb_pipe.sv
// Two-stage elastic two's-complement to sign/exp/mant converter.
// S1 registers sign and magnitude; S2 normalises into the output float.
module floatb_pipe
   import floatb_pkg::*;
#(
   parameter int DW        = G726_DW,
   parameter int MW        = G726_MW,
   parameter int CH        = 4,
   parameter bit ZERO_HALF = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW-1:0]          in_sr,
   input  logic [ch_w(CH)-1:0]    in_ch,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [fl_w(DW,MW)-1:0] out_fl,
   output logic [ch_w(CH)-1:0]    out_ch,
   output logic                   out_zero
);

   localparam int EW = exp_w(DW);
   localparam int CW = ch_w(CH);
   localparam int WW = DW + MW;

   logic          s1_valid;
   logic          s1_sign;
   logic [DW-2:0] s1_mag;
   logic [CW-1:0] s1_ch;
   logic          s1_adv;
   logic          s2_adv;
   logic          in_acc;
   logic [DW-1:0] neg_sr;
   logic [EW-1:0] lz_exp;
   logic          lz_zero;
   logic [WW-1:0] shifted;
   logic [MW-1:0] mant;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   assign in_ready = !s1_valid || s1_adv;
   assign in_acc   = in_valid && in_ready;
   // Most-negative input wraps to magnitude 0, matching G.726
   assign neg_sr   = -in_sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
         s1_ch    <= '0;
      end else if (in_acc) begin
         s1_valid <= 1'b1;
         s1_sign  <= in_sr[DW-1];
         s1_mag   <= in_sr[DW-1] ? neg_sr[DW-2:0] : in_sr[DW-2:0];
         s1_ch    <= in_ch;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   floatb_lzd #(
      .N  (DW - 1),
      .EW (EW)
   ) u_lzd (
      .mag  (s1_mag),
      .exp  (lz_exp),
      .zero (lz_zero)
   );

   always_comb begin
      shifted = ({{(MW + 1){1'b0}}, s1_mag} << MW) >> lz_exp;
      mant    = shifted[MW-1:0];
      if (lz_zero)
         mant = ZERO_HALF ? (MW'(1) << (MW - 1)) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_fl    <= '0;
         out_ch    <= '0;
         out_zero  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_fl   <= {s1_sign, lz_exp, mant};
            out_ch   <= s1_ch;
            out_zero <= lz_zero;
         end
      end
   end

endmodule

// File: tb/tb_floatb_pipe.sv
// Bench for floatb_pipe: G.726 instance plus a DW=12/MW=4 instance.
// Scoreboard fed from an arithmetic model; table vectors and sequences.
module tb_floatb_pipe;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [15:0] in_sr;
   logic [1:0]  in_ch, out_ch;
   logic [10:0] out_fl;

   logic        in_valid12, in_ready12, out_valid12, out_ready12, out_zero12;
   logic [11:0] in_sr12;
   logic [1:0]  in_ch12, out_ch12;
   logic [8:0]  out_fl12;

   int nvec = 0;
   int nbad = 0;

   typedef struct packed {
      logic        zero;
      logic [1:0]  ch;
      logic [31:0] fl;
   } exp_t;

   typedef struct {
      logic [15:0] sr;
      logic [10:0] fl;
      logic        zero;
   } vec_t;

   exp_t        q16[$];
   exp_t        q12[$];
   exp_t        e16, e12;
   logic [32:0] m16, m12;
   logic        stall16 = 1'b0;
   logic [14:0] hold16 = '0;

   floatb_pipe u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sr     (in_sr),
      .in_ch     (in_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fl    (out_fl),
      .out_ch    (out_ch),
      .out_zero  (out_zero)
   );

   floatb_pipe #(
      .DW        (12),
      .MW        (4),
      .CH        (4),
      .ZERO_HALF (1'b0)
   ) u_dut12 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid12),
      .in_ready  (in_ready12),
      .in_sr     (in_sr12),
      .in_ch     (in_ch12),
      .out_valid (out_valid12),
      .out_ready (out_ready12),
      .out_fl    (out_fl12),
      .out_ch    (out_ch12),
      .out_zero  (out_zero12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Float from plain integer arithmetic: returns {zero, fl}
   function automatic logic [32:0] model(input int dw, input int mw,
                                         input bit zh, input longint x);
      longint one = 1;
      longint sign, v, mag, e, ew, mant;
      sign = (x >> (dw - 1)) & 1;
      v    = (sign != 0) ? x - (one << dw) : x;
      mag  = ((v < 0) ? -v : v) % (one << (dw - 1));
      e = 0;
      while ((one << e) <= mag) e++;
      ew = 0;
      while ((one << ew) < dw) ew++;
      if (mag == 0) mant = zh ? (one << (mw - 1)) : 0;
      else          mant = ((mag << mw) >> e) % (one << mw);
      return {1'(mag == 0), 32'((sign << (ew + mw)) | (e << mw) | mant)};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q16.delete();
         q12.delete();
         stall16 = 1'b0;
      end else begin
         if (stall16)
            chk("stall_hold", {out_valid, out_zero, out_ch, out_fl}, hold16);
         if (out_valid && out_ready) begin
            if (q16.size() == 0) chk("extra16", 64'(q16.size()), 64'd1);
            else begin
               e16 = q16.pop_front();
               chk("out16", {out_zero, out_ch, out_fl},
                   {e16.zero, e16.ch, e16.fl[10:0]});
            end
         end
         stall16 = out_valid && !out_ready;
         hold16  = {out_valid, out_zero, out_ch, out_fl};
         if (in_valid && in_ready) begin
            m16 = model(16, 6, 1'b1, longint'(in_sr));
            q16.push_back({m16[32], in_ch, m16[31:0]});
         end

         if (out_valid12 && out_ready12) begin
            if (q12.size() == 0) chk("extra12", 64'(q12.size()), 64'd1);
            else begin
               e12 = q12.pop_front();
               chk("out12", {out_zero12, out_ch12, out_fl12},
                   {e12.zero, e12.ch, e12.fl[8:0]});
            end
         end
         if (in_valid12 && in_ready12) begin
            m12 = model(12, 4, 1'b0, longint'(in_sr12));
            q12.push_back({m12[32], in_ch12, m12[31:0]});
         end
      end
   end

   task automatic send16(input logic [15:0] sr, input logic [1:0] ch,
                         input logic [10:0] fl, input logic z);
      in_valid  = 1'b1;
      in_sr     = sr;
      in_ch     = ch;
      out_ready = 1'b1;
      #1;
      chk("acc16", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat1_16", out_valid, 0);
      @(posedge clk); #1;
      chk("lat2_16", {out_valid, out_zero, out_fl}, {1'b1, z, fl});
   endtask

   task automatic send12(input logic [11:0] sr, input logic [1:0] ch,
                         input logic [8:0] fl, input logic z);
      in_valid12  = 1'b1;
      in_sr12     = sr;
      in_ch12     = ch;
      out_ready12 = 1'b1;
      #1;
      chk("acc12", in_ready12, 1);
      @(posedge clk); #1;
      in_valid12 = 1'b0;
      chk("lat1_12", out_valid12, 0);
      @(posedge clk); #1;
      chk("lat2_12", {out_valid12, out_zero12, out_fl12}, {1'b1, z, fl});
   endtask

   initial begin
      vec_t        tbl[6];
      logic [15:0] sv[8];
      int          k;
      int          acc;
      int          cyc;

      tbl = '{'{16'h0000, 11'h020, 1'b1},
              '{16'h0001, 11'h060, 1'b0},
              '{16'h0100, 11'h260, 1'b0},
              '{16'h7FFF, 11'h3FF, 1'b0},
              '{16'hFFFF, 11'h460, 1'b0},
              '{16'h8000, 11'h420, 1'b1}};

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_sr       = '0;
      in_ch       = '0;
      out_ready   = 1'b1;
      in_valid12  = 1'b0;
      in_sr12     = '0;
      in_ch12     = '0;
      out_ready12 = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state16", {out_valid, out_zero, out_ch, out_fl}, 0);
      chk("rst_state12", {out_valid12, out_zero12, out_ch12, out_fl12}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {in_ready, in_ready12}, 2'b11);

      for (int i = 0; i < 6; i++)
         send16(tbl[i].sr, 2'(i), tbl[i].fl, tbl[i].zero);

      // Backpressure: out_ready low for cycles 3..5
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) sv[i] = 16'($urandom);
      k = 0;
      for (int c = 0; c < 25; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         in_valid  = (k < 8);
         in_sr     = sv[k % 8];
         in_ch     = 2'(k);
         #1;
         if (c >= 3 && c <= 5) chk("bp_in_ready", in_ready, 0);
         if (in_valid && in_ready) k++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_count", k, 8);
      chk("bp_drain", q16.size(), 0);

      // Reset with two samples in flight
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sr     = 16'h1234;
      in_ch     = 2'd1;
      @(posedge clk); #1;
      in_sr = 16'h8001;
      in_ch = 2'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid", {out_valid, out_fl}, 0);
      rst_n = 1'b1;
      send16(16'h0040, 2'd3, 11'h1E0, 1'b0);

      // Exhaustive sweep of the DW=12 instance
      for (int x = 0; x < 4096; x++) begin
         in_valid12 = 1'b1;
         in_sr12    = 12'(x);
         in_ch12    = 2'(x);
         @(posedge clk); #1;
      end
      in_valid12 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("ex12_drain", q12.size(), 0);
      send12(12'h800, 2'd0, 9'h100, 1'b1);
      send12(12'h7FF, 2'd1, 9'h0BF, 1'b0);

      // Random traffic with random backpressure
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 40000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 7))
            0:       in_sr = 16'h8000;
            1:       in_sr = 16'h0000;
            2:       in_sr = 16'hFFFF;
            default: in_sr = 16'($urandom);
         endcase
         in_ch = 2'($urandom_range(0, 3));
         #1;
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("rand_count", acc, 10000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rand_drain", q16.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/floatb_pipe.md
Name: floatb_pipe

Overview:
Parametrised, pipelined successor to the G.726 FLOATB conversion. Converts a DW-bit two's-complement sample to the sign/exponent/mantissa float format used by the predictor (SR0 style). Accepts a time-multiplexed stream from CH channels over a valid/ready handshake and carries a channel tag alongside each sample. Sits between the reconstructed-signal adder and the pole/zero predictor delay lines of the multi-channel ADPCM core.

Parameters:
DW, 16, input sample width (two's complement); legal range 4..32
MW, 6, mantissa width
CH, 4, number of channels; tag width CW = max(1, clog2(CH))
ZERO_HALF, 1, 1: MAG==0 gives mantissa 1<<(MW-1) (G.726 rule); 0: mantissa 0
Derived: EW = clog2(DW); OW = 1 + EW + MW (DW=16, MW=6 gives EW=4, OW=11)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_sr  in  DW  two's-complement sample
in_ch  in  CW  channel tag
out_valid  out  1  output float valid
out_ready  in  1  downstream accepts
out_fl  out  OW  {sign, exp[EW-1:0], mant[MW-1:0]}
out_ch  out  CW  tag of out_fl
out_zero  out  1  magnitude was zero

Behaviour:
- One clock. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_fl=0, out_ch=0, out_zero=0, all stage valids 0. in_ready=1 the cycle after reset releases.
- Transfer occurs when valid && ready on a clock edge.
- Stage S1 (register on input accept):
  - sign = in_sr[DW-1].
  - mag = sign ? ((2^DW - in_sr) & (2^(DW-1)-1)) : in_sr[DW-2:0].
  - For the most-negative input: mag = 0, sign = 1, as in G.726.
- Stage S2 (register into output):
  - exp = index of the leading one of mag, plus 1; exp = 0 when mag = 0.
  - mant = mag==0 ? (ZERO_HALF ? 1<<(MW-1) : 0) : ((mag << MW) >> exp)[MW-1:0].
  - out_fl = {sign, exp, mant}. out_zero = (mag==0).
  - Shift arithmetic is done at width DW+MW; no truncation before the final slice.
- Latency: 2 cycles from input accept to out_valid with no backpressure.
  - Throughput: 1 sample per cycle.
- Pipeline control is elastic, with no bubbles and no drops:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances into S2 when s1_valid && S2 advances.
  - in_ready = !s1_valid || S1 advances (combinational from out_ready; no path from in_valid to in_ready).
  - Maximum 2 samples in flight; with out_ready held low, in_ready drops once both stages are full.
- Stall: out_fl, out_ch and out_zero hold stable while out_valid && !out_ready.
- Simultaneous accept and emit in the same cycle: both occur and the pipeline stays full.
- Reset mid-stream: all in-flight samples are discarded and out_valid goes to 0 on the reset edge. No partial output.
- Channel tag passes through unchanged; ordering is strictly FIFO.

Decomposition:
- Package floatb_pkg holds:
  - clog2 function
  - EW/OW derivation
  - a packed struct for {sign, exp, mant}
  - the G.726 constants DW=16, MW=6
- One sub-module, floatb_lzd: combinational leading-one detector, parametrised on DW-1, returns the exponent and a zero flag. It is instantiated in S2.

Test Plan:
1. Defaults, ZERO_HALF=1, out_ready=1. Send in_sr = 0x0000, 0x0001, 0x0100, 0x7FFF. Expected out_fl = 0x020, 0x060, 0x260, 0x3FF, each 2 cycles after accept.
2. Send in_sr = 0xFFFF, then 0x8000. Expected out_fl = 0x460 (out_zero=0), then 0x420 (out_zero=1).
3. Backpressure. Stream 8 samples on alternating in_ch 0..3 with out_ready low for cycles 3-5. Expected: in_ready low after 2 samples are held; all 8 outputs appear in order with correct tags; outputs stay stable during the stall.
4. Reset mid-stream. Assert rst_n=0 for one cycle with 2 samples in flight. Expected: out_valid=0 on the next cycle; first post-reset sample emerges after exactly 2 cycles.
5. Parameter sweep: DW=12, MW=4, ZERO_HALF=0, with exhaustive in_sr against the reference model. Expected: 0x800 gives {1, 0, 0}; 0x7FF gives exp=11, mant=0xF.
6. Randomised 10k samples with random in_valid/out_ready compared against a scoreboard. Expected: zero mismatches and zero lost or duplicated samples.
